// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback buffer.
// Entry layout is shared with the WB stage and the bench.
package wb_pkg;

  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first match of one read index against pending writebacks.
// Scans from head (oldest) to tail so later matches override.
module wb_fwd_match #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = PW + 1
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic [PW-1:0]     head_i,
  input  logic [CW-1:0]     count_i,
  input  logic [ADDR_W-1:0] rd_i   [DEPTH],
  input  logic [DATA_W-1:0] data_i [DEPTH],
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    logic [PW-1:0] idx;
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if ((CW'(i) < count_i) && (rs_i != '0) &&
          (rd_i[idx] == rs_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// In-order writeback FIFO in front of the register file write port.
// Pending entries forward to both read ports until drained.
module writeback_buffer
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [ADDR_W-1:0]        In_RD,
  input  logic [DATA_W-1:0]        In_Data,
  input  logic                     Drain_En,
  output logic                     RF_RegWrite,
  output logic [ADDR_W-1:0]        RF_RD,
  output logic [DATA_W-1:0]        RF_WriteData,
  input  logic [ADDR_W-1:0]        RS1,
  input  logic [ADDR_W-1:0]        RS2,
  output logic                     Fwd1_Hit,
  output logic                     Fwd2_Hit,
  output logic [DATA_W-1:0]        Fwd1_Data,
  output logic [DATA_W-1:0]        Fwd2_Data,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  assign Empty    = (count_q == '0);
  assign Full     = (count_q == CW'(DEPTH));
  assign Count    = count_q;
  assign In_Ready = !Full;

  // x0 requests complete the handshake but are never stored
  assign push = In_Valid && In_Ready && (In_RD != '0);
  assign pop  = !Empty && Drain_En;

  assign RF_RegWrite  = pop;
  assign RF_RD        = Empty ? '0 : rd_q[head_q];
  assign RF_WriteData = Empty ? '0 : data_q[head_q];

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      rd_q[tail_q]   <= In_RD;
      data_q[tail_q] <= In_Data;
    end
  end

  wb_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fwd1 (
    .rs_i    (RS1),
    .head_i  (head_q),
    .count_i (count_q),
    .rd_i    (rd_q),
    .data_i  (data_q),
    .hit_o   (Fwd1_Hit),
    .data_o  (Fwd1_Data)
  );

  wb_fwd_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fwd2 (
    .rs_i    (RS2),
    .head_i  (head_q),
    .count_i (count_q),
    .rd_i    (rd_q),
    .data_i  (data_q),
    .hit_o   (Fwd2_Hit),
    .data_o  (Fwd2_Data)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer.
// Expected RF writes are queued on accept and popped on drain.
module tb_writeback_buffer;
  import wb_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  In_RD;
  logic [63:0] In_Data;
  logic        Drain_En;
  logic        RF_RegWrite;
  logic [4:0]  RF_RD;
  logic [63:0] RF_WriteData;
  logic [4:0]  RS1, RS2;
  logic        Fwd1_Hit, Fwd2_Hit;
  logic [63:0] Fwd1_Data, Fwd2_Data;
  logic [2:0]  Count;
  logic        Empty, Full;

  int n_chk  = 0;
  int n_pass = 0;
  wb_entry_t sb[$];

  writeback_buffer #(.DATA_W(64), .ADDR_W(5), .DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_RD(In_RD), .In_Data(In_Data),
    .Drain_En(Drain_En),
    .RF_RegWrite(RF_RegWrite), .RF_RD(RF_RD),
    .RF_WriteData(RF_WriteData),
    .RS1(RS1), .RS2(RS2),
    .Fwd1_Hit(Fwd1_Hit), .Fwd2_Hit(Fwd2_Hit),
    .Fwd1_Data(Fwd1_Data), .Fwd2_Data(Fwd2_Data),
    .Count(Count), .Empty(Empty), .Full(Full)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge Clk) begin
    if (Reset_n && RF_RegWrite) begin
      if (sb.size() == 0) begin
        chk("rf_unexpected", 64'd1, 64'd0);
      end else begin
        wb_entry_t e;
        e = sb.pop_front();
        chk("rf_rd", 64'(RF_RD), 64'(e.rd));
        chk("rf_data", RF_WriteData, e.data);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rd, input logic [63:0] d);
    bit acc;
    acc = 1'b0;
    In_Valid = 1'b1;
    In_RD    = rd;
    In_Data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge Clk);
      if (In_Ready) begin
        acc = 1'b1;
        if (rd != 5'd0) sb.push_back('{rd: rd, data: d});
      end
      step();
    end
    In_Valid = 1'b0;
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain_all();
    bit done;
    done = 1'b0;
    Drain_En = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clk);
      done = Empty;
      step();
    end
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    Reset_n  = 1'b0;
    In_Valid = 1'b0;
    In_RD    = '0;
    In_Data  = '0;
    Drain_En = 1'b0;
    RS1      = '0;
    RS2      = '0;

    // reset state
    #12;
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_ready", 64'(In_Ready), 64'd1);
    chk("rst_full", 64'(Full), 64'd0);
    chk("rst_regwrite", 64'(RF_RegWrite), 64'd0);
    chk("rst_rf_rd", 64'(RF_RD), 64'd0);
    chk("rst_rf_data", RF_WriteData, 64'd0);
    chk("rst_fwd1", 64'(Fwd1_Hit), 64'd0);
    chk("rst_fwd2", 64'(Fwd2_Hit), 64'd0);
    step();
    Reset_n = 1'b1;
    step();

    // single write
    Drain_En = 1'b1;
    RS1 = 5'd5;
    send(5'd5, 64'hA5);
    @(negedge Clk);
    chk("sw_regwrite", 64'(RF_RegWrite), 64'd1);
    chk("sw_rd", 64'(RF_RD), 64'd5);
    chk("sw_data", RF_WriteData, 64'hA5);
    chk("sw_fwd1_hit", 64'(Fwd1_Hit), 64'd1);
    chk("sw_fwd1_data", Fwd1_Data, 64'hA5);
    step();
    @(negedge Clk);
    chk("sw_empty", 64'(Empty), 64'd1);
    chk("sw_fwd1_gone", 64'(Fwd1_Hit), 64'd0);
    step();

    // x0 discard
    send(5'd0, 64'hFF);
    @(negedge Clk);
    chk("x0_count", 64'(Count), 64'd0);
    chk("x0_regwrite", 64'(RF_RegWrite), 64'd0);
    step();

    // same-register ordering
    Drain_En = 1'b0;
    RS2 = 5'd7;
    send(5'd7, 64'd1);
    send(5'd7, 64'd2);
    @(negedge Clk);
    chk("ord_count", 64'(Count), 64'd2);
    chk("ord_fwd2_hit", 64'(Fwd2_Hit), 64'd1);
    chk("ord_fwd2_stall", Fwd2_Data, 64'd2);
    step();
    Drain_En = 1'b1;
    @(negedge Clk);
    chk("ord_wr1", RF_WriteData, 64'd1);
    chk("ord_fwd2_a", Fwd2_Data, 64'd2);
    step();
    @(negedge Clk);
    chk("ord_wr2", RF_WriteData, 64'd2);
    chk("ord_fwd2_b", Fwd2_Data, 64'd2);
    step();
    @(negedge Clk);
    chk("ord_empty", 64'(Empty), 64'd1);
    chk("ord_fwd2_gone", 64'(Fwd2_Hit), 64'd0);
    step();

    // full, with youngest-match check on RS1
    Drain_En = 1'b0;
    RS1 = 5'd3;
    for (int i = 1; i <= 4; i++) send(5'(i), 64'(16 * i));
    In_Valid = 1'b1;
    In_RD    = 5'd9;
    In_Data  = 64'h99;
    @(negedge Clk);
    chk("full_full", 64'(Full), 64'd1);
    chk("full_ready", 64'(In_Ready), 64'd0);
    chk("full_count", 64'(Count), 64'd4);
    chk("full_fwd1", Fwd1_Data, 64'd48);
    step();
    @(negedge Clk);
    chk("full_nostore", 64'(Count), 64'd4);
    step();
    Drain_En = 1'b1;
    @(negedge Clk);
    chk("full_pop_ready", 64'(In_Ready), 64'd0);
    chk("full_pop_rw", 64'(RF_RegWrite), 64'd1);
    step();
    @(negedge Clk);
    chk("full_dec", 64'(Count), 64'd3);
    chk("full_ready2", 64'(In_Ready), 64'd1);
    if (In_Ready) sb.push_back('{rd: 5'd9, data: 64'h99});
    step();
    In_Valid = 1'b0;
    @(negedge Clk);
    chk("full_pushpop", 64'(Count), 64'd3);
    step();
    drain_all();

    // random traffic checked by the scoreboard
    for (int c = 0; c < 200; c++) begin
      In_Valid = 1'($urandom);
      In_RD    = 5'($urandom_range(0, 7));
      In_Data  = {32'($urandom), 32'($urandom)};
      Drain_En = ($urandom_range(0, 3) != 0);
      RS1      = 5'($urandom_range(0, 7));
      @(negedge Clk);
      if (In_Valid && In_Ready && In_RD != 5'd0)
        sb.push_back('{rd: In_RD, data: In_Data});
      step();
    end
    In_Valid = 1'b0;
    drain_all();

    // async reset with entries pending
    Drain_En = 1'b0;
    for (int i = 1; i <= 3; i++) send(5'(i + 10), 64'(i));
    Drain_En = 1'b1;
    #1;
    chk("ar_pending_rw", 64'(RF_RegWrite), 64'd1);
    Reset_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_regwrite", 64'(RF_RegWrite), 64'd0);
    chk("ar_empty", 64'(Empty), 64'd1);
    chk("ar_count", 64'(Count), 64'd0);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge Clk);
    chk("ar_post_empty", 64'(Empty), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
